// File: rtl/ysyx_210544_dcache_arbiter.sv
// Two-requester arbiter (data, instruction-fetch) in front of a single dcache port.
// Define YSYX210544_DCACHE_ARB_RR_EN for round-robin on simultaneous requests; default is fixed data priority.
module ysyx_210544_dcache_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_d_req,
    input  logic [63:0] i_d_addr,
    input  logic        i_d_op,
    input  logic [2:0]  i_d_bytes,
    input  logic [63:0] i_d_wdata,
    output logic        o_d_ack,
    output logic [63:0] o_d_rdata,
    input  logic        i_i_req,
    input  logic [63:0] i_i_addr,
    input  logic        i_i_op,
    input  logic [2:0]  i_i_bytes,
    input  logic [63:0] i_i_wdata,
    output logic        o_i_ack,
    output logic [63:0] o_i_rdata,
    output logic        o_cache_req,
    output logic [63:0] o_cache_addr,
    output logic        o_cache_op,
    output logic [2:0]  o_cache_bytes,
    output logic [63:0] o_cache_wdata,
    input  logic        i_cache_ack,
    input  logic [63:0] i_cache_rdata,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_D,
        S_BUSY_I,
        S_RESP_D,
        S_RESP_I
    } state_t;

    state_t r_state;
    logic   w_prio_d;
    logic   w_grant_d;

`ifdef YSYX210544_DCACHE_ARB_RR_EN
    // Set when the instruction requester was granted most recently
    logic r_last_i;
    assign w_prio_d = r_last_i;
`else
    assign w_prio_d = 1'b1;
`endif

    assign w_grant_d = i_d_req && (!i_i_req || w_prio_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            o_cache_req   <= 1'b0;
            o_cache_addr  <= 64'd0;
            o_cache_op    <= 1'b0;
            o_cache_bytes <= 3'd0;
            o_cache_wdata <= 64'd0;
            o_d_ack       <= 1'b0;
            o_i_ack       <= 1'b0;
            o_d_rdata     <= 64'd0;
            o_i_rdata     <= 64'd0;
            o_busy        <= 1'b0;
`ifdef YSYX210544_DCACHE_ARB_RR_EN
            r_last_i      <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        o_cache_req   <= 1'b1;
                        o_cache_addr  <= i_d_addr;
                        o_cache_op    <= i_d_op;
                        o_cache_bytes <= i_d_bytes;
                        o_cache_wdata <= i_d_wdata;
                        o_busy        <= 1'b1;
                        r_state       <= S_BUSY_D;
`ifdef YSYX210544_DCACHE_ARB_RR_EN
                        r_last_i      <= 1'b0;
`endif
                    end else if (i_i_req) begin
                        o_cache_req   <= 1'b1;
                        o_cache_addr  <= i_i_addr;
                        o_cache_op    <= i_i_op;
                        o_cache_bytes <= i_i_bytes;
                        o_cache_wdata <= i_i_wdata;
                        o_busy        <= 1'b1;
                        r_state       <= S_BUSY_I;
`ifdef YSYX210544_DCACHE_ARB_RR_EN
                        r_last_i      <= 1'b1;
`endif
                    end
                end
                S_BUSY_D: begin
                    if (i_cache_ack) begin
                        o_cache_req <= 1'b0;
                        o_d_rdata   <= o_cache_op ? 64'd0 : i_cache_rdata;
                        o_d_ack     <= 1'b1;
                        r_state     <= S_RESP_D;
                    end
                end
                S_BUSY_I: begin
                    if (i_cache_ack) begin
                        o_cache_req <= 1'b0;
                        o_i_rdata   <= o_cache_op ? 64'd0 : i_cache_rdata;
                        o_i_ack     <= 1'b1;
                        r_state     <= S_RESP_I;
                    end
                end
                S_RESP_D: begin
                    o_d_ack <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_RESP_I: begin
                    o_i_ack <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_cache_req <= 1'b0;
                    o_d_ack     <= 1'b0;
                    o_i_ack     <= 1'b0;
                    o_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_210544_dcache_arbiter.sv
// Directed bench for ysyx_210544_dcache_arbiter; expected grant order follows YSYX210544_DCACHE_ARB_RR_EN.
module tb_ysyx_210544_dcache_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_d_req, i_d_op, i_i_req, i_i_op, i_cache_ack;
    logic [63:0] i_d_addr, i_d_wdata, i_i_addr, i_i_wdata, i_cache_rdata;
    logic [2:0]  i_d_bytes, i_i_bytes;
    logic        o_d_ack, o_i_ack, o_cache_req, o_cache_op, o_busy;
    logic [63:0] o_d_rdata, o_i_rdata, o_cache_addr, o_cache_wdata;
    logic [2:0]  o_cache_bytes;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] D_ADDR = 64'h0000_0000_8000_1000;
    localparam logic [63:0] I_ADDR = 64'h0000_0000_8000_0040;

    ysyx_210544_dcache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_d_req(i_d_req), .i_d_addr(i_d_addr), .i_d_op(i_d_op),
        .i_d_bytes(i_d_bytes), .i_d_wdata(i_d_wdata),
        .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
        .i_i_req(i_i_req), .i_i_addr(i_i_addr), .i_i_op(i_i_op),
        .i_i_bytes(i_i_bytes), .i_i_wdata(i_i_wdata),
        .o_i_ack(o_i_ack), .o_i_rdata(o_i_rdata),
        .o_cache_req(o_cache_req), .o_cache_addr(o_cache_addr), .o_cache_op(o_cache_op),
        .o_cache_bytes(o_cache_bytes), .o_cache_wdata(o_cache_wdata),
        .i_cache_ack(i_cache_ack), .i_cache_rdata(i_cache_rdata),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_d_req = 1'b0; i_i_req = 1'b0; i_cache_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One arbitration round: both requesters (or only I) present in IDLE
    task automatic run_round(input string tag, input logic raise_d, input logic exp_d,
                             input logic [63:0] rdata);
        i_d_req = raise_d;
        i_i_req = 1'b1;
        @(negedge clk);
        check({tag, "_req"},  64'(o_cache_req), 64'd1);
        check({tag, "_addr"}, o_cache_addr, exp_d ? D_ADDR : I_ADDR);
        i_cache_ack = 1'b1;
        i_cache_rdata = rdata;
        @(negedge clk);
        check({tag, "_dack"}, 64'(o_d_ack), 64'(exp_d));
        check({tag, "_iack"}, 64'(o_i_ack), 64'(!exp_d));
        check({tag, "_rdata"}, exp_d ? o_d_rdata : o_i_rdata, rdata);
        i_cache_ack = 1'b0;
        if (exp_d) i_d_req = 1'b0;
        else       i_i_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        i_d_addr = 64'd0; i_d_op = 1'b0; i_d_bytes = 3'd0; i_d_wdata = 64'd0;
        i_i_addr = 64'd0; i_i_op = 1'b0; i_i_bytes = 3'd0; i_i_wdata = 64'd0;
        i_cache_rdata = 64'd0;
        do_reset();
        check("rst_req",   64'(o_cache_req), 64'd0);
        check("rst_busy",  64'(o_busy), 64'd0);
        check("rst_addr",  o_cache_addr, 64'd0);
        check("rst_drd",   o_d_rdata, 64'd0);

        // Single data read
        i_d_req = 1'b1; i_d_addr = D_ADDR; i_d_op = 1'b0; i_d_bytes = 3'd7;
        @(negedge clk);
        check("rd_req",   64'(o_cache_req), 64'd1);
        check("rd_addr",  o_cache_addr, D_ADDR);
        check("rd_op",    64'(o_cache_op), 64'd0);
        check("rd_bytes", 64'(o_cache_bytes), 64'd7);
        check("rd_busy",  64'(o_busy), 64'd1);
        check("rd_noack", 64'(o_d_ack), 64'd0);
        i_cache_ack = 1'b1; i_cache_rdata = 64'h1122_3344_5566_7788;
        @(negedge clk);
        check("rd_ack",   64'(o_d_ack), 64'd1);
        check("rd_data",  o_d_rdata, 64'h1122_3344_5566_7788);
        check("rd_creq0", 64'(o_cache_req), 64'd0);
        check("rd_iack0", 64'(o_i_ack), 64'd0);
        i_cache_ack = 1'b0; i_d_req = 1'b0; i_cache_rdata = 64'd0;
        @(negedge clk);
        check("rd_ackpulse", 64'(o_d_ack), 64'd0);
        check("rd_idle",     64'(o_busy), 64'd0);
        check("rd_hold",     o_d_rdata, 64'h1122_3344_5566_7788);
        // Stray cache ack while idle
        i_cache_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_d", 64'(o_d_ack), 64'd0);
        check("idle_ack_i", 64'(o_i_ack), 64'd0);
        check("idle_busy",  64'(o_busy), 64'd0);
        i_cache_ack = 1'b0;

        // Simultaneous requests, three back-to-back rounds, then instruction alone
        do_reset();
        i_d_addr = D_ADDR; i_i_addr = I_ADDR; i_d_op = 1'b0; i_i_op = 1'b0;
`ifdef YSYX210544_DCACHE_ARB_RR_EN
        run_round("r1", 1'b1, 1'b1, 64'hD1);
        run_round("r2", 1'b1, 1'b0, 64'hA2);
        run_round("r3", 1'b1, 1'b1, 64'hD3);
`else
        run_round("r1", 1'b1, 1'b1, 64'hD1);
        run_round("r2", 1'b1, 1'b1, 64'hD2);
        run_round("r3", 1'b1, 1'b1, 64'hD3);
`endif
        run_round("r4", 1'b0, 1'b0, 64'hA4);

        // Writes from both requesters: rdata returned as 0
        i_d_req = 1'b1; i_d_op = 1'b1; i_d_wdata = 64'hDEAD; i_d_bytes = 3'd1;
        @(negedge clk);
        check("wd_wdata", o_cache_wdata, 64'hDEAD);
        check("wd_op",    64'(o_cache_op), 64'd1);
        check("wd_bytes", 64'(o_cache_bytes), 64'd1);
        i_cache_ack = 1'b1; i_cache_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("wd_ack",   64'(o_d_ack), 64'd1);
        check("wd_rdata", o_d_rdata, 64'd0);
        i_cache_ack = 1'b0; i_d_req = 1'b0;
        @(negedge clk);
        i_i_req = 1'b1; i_i_op = 1'b1; i_i_wdata = 64'hDEAD; i_i_bytes = 3'd1;
        @(negedge clk);
        check("wi_wdata", o_cache_wdata, 64'hDEAD);
        check("wi_addr",  o_cache_addr, I_ADDR);
        i_cache_ack = 1'b1;
        @(negedge clk);
        check("wi_ack",   64'(o_i_ack), 64'd1);
        check("wi_rdata", o_i_rdata, 64'd0);
        i_cache_ack = 1'b0; i_i_req = 1'b0; i_i_op = 1'b0;
        @(negedge clk);

        // Reset in the middle of an instruction transaction
        i_i_req = 1'b1;
        @(negedge clk);
        check("ri_busy", 64'(o_busy), 64'd1);
        check("ri_req",  64'(o_cache_req), 64'd1);
        rst = 1'b1; i_i_req = 1'b0;
        @(negedge clk);
        check("ri_req0",  64'(o_cache_req), 64'd0);
        check("ri_busy0", 64'(o_busy), 64'd0);
        check("ri_iack0", 64'(o_i_ack), 64'd0);
        check("ri_addr0", o_cache_addr, 64'd0);
        rst = 1'b0; i_cache_ack = 1'b1; i_cache_rdata = 64'h55;
        @(negedge clk);
        check("ri_late_iack", 64'(o_i_ack), 64'd0);
        check("ri_late_busy", 64'(o_busy), 64'd0);
        check("ri_late_rd",   o_i_rdata, 64'd0);
        i_cache_ack = 1'b0;
        @(negedge clk);

        // Stalled cache ack with requester dropping mid-transaction
        i_d_req = 1'b1; i_d_op = 1'b0; i_d_addr = 64'h8000_3000; i_d_bytes = 3'd3;
        i_d_wdata = 64'h77;
        @(negedge clk);
        i_d_req = 1'b0; i_d_addr = 64'h0; i_d_bytes = 3'd0;
        for (int k = 0; k < 20; k++) begin
            check("st_req",   64'(o_cache_req), 64'd1);
            check("st_addr",  o_cache_addr, 64'h8000_3000);
            check("st_bytes", 64'(o_cache_bytes), 64'd3);
            check("st_wdata", o_cache_wdata, 64'h77);
            check("st_busy",  64'(o_busy), 64'd1);
            @(negedge clk);
        end
        i_cache_ack = 1'b1; i_cache_rdata = 64'hCAFE_F00D;
        @(negedge clk);
        check("st_ack",   64'(o_d_ack), 64'd1);
        check("st_rdata", o_d_rdata, 64'hCAFE_F00D);
        i_cache_ack = 1'b0;
        @(negedge clk);
        check("st_ack0",  64'(o_d_ack), 64'd0);
        check("st_idle",  64'(o_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_210544_dcache_arbiter.md
YSYX_210544_DCACHE_ARBITER -- requirements
Module: ysyx_210544_dcache_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  clock, all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: i_d_req  input  1  data requester (memory stage) request, held high until acked.
REQ-004 SHALL have ports: i_d_addr/i_d_op/i_d_bytes/i_d_wdata  input  64/1/3/64  data address, op (0 read, 1 write), byte count minus 1, write data.
REQ-005 SHALL have ports: o_d_ack  output  1  one-cycle completion pulse; o_d_rdata  output  64  read data, valid with o_d_ack.
REQ-006 SHALL have ports: i_i_req, i_i_addr, i_i_op, i_i_bytes, i_i_wdata, o_i_ack, o_i_rdata  (same widths)  instruction-fetch requester.
REQ-007 SHALL have ports: o_cache_req  output  1; o_cache_addr/o_cache_op/o_cache_bytes/o_cache_wdata  output  64/1/3/64  shared cache port.
REQ-008 SHALL have ports: i_cache_ack  input  1  one-cycle completion pulse; i_cache_rdata  input  64  valid with i_cache_ack.
REQ-009 SHALL have ports: o_busy  output  1  high in any state other than IDLE.
REQ-010 SHALL drive every output from a register.

Function
REQ-011 SHALL implement states IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I.
REQ-012 SHALL, in IDLE with any request high, grant one requester, latch its addr/op/bytes/wdata into the o_cache_* registers, set o_cache_req=1, and enter BUSY_D or BUSY_I at the same edge.
REQ-013 SHALL, in IDLE with both requests high, grant the data requester unless overridden by REQ-024.
REQ-014 SHALL hold o_cache_req and all o_cache_* fields stable in BUSY_x until i_cache_ack=1.
REQ-015 SHALL, on the edge where i_cache_ack=1 in BUSY_x, clear o_cache_req, capture i_cache_rdata into o_x_rdata (0 when op=1), set o_x_ack=1, and enter RESP_x.
REQ-016 SHALL hold o_x_ack high for exactly one cycle (RESP_x), then clear it and return to IDLE.
REQ-017 SHALL not grant in RESP_x; requesters drop req on the edge after observing ack, so IDLE after RESP sees no stale request.
REQ-018 SHALL achieve latency: o_cache_req high 1 cycle after request seen in IDLE; o_x_ack high 1 cycle after i_cache_ack.
REQ-019 SHALL ignore i_cache_ack in IDLE and RESP_x; no ack is forwarded.
REQ-020 SHALL ignore request deassertion in BUSY_x; the transaction completes and its ack is still issued.
REQ-021 SHALL keep o_d_rdata/o_i_rdata at their last captured value outside RESP_x.

Reset
REQ-022 SHALL, on rst=1 at any edge, including mid-transaction, enter IDLE and clear o_cache_req, o_cache_addr, o_cache_op, o_cache_bytes, o_cache_wdata, o_d_ack, o_i_ack, o_d_rdata, o_i_rdata, and o_busy to 0.
REQ-023 SHALL, on reset, reset the round-robin pointer to "last granted = instruction", so the data requester wins first.

Configuration
REQ-024 SHALL support macro YSYX210544_DCACHE_ARB_RR_EN: when defined, use round-robin on simultaneous requests, granting the requester not granted last, with the pointer updated at each grant; when undefined, data always wins and no pointer register exists.
REQ-025 SHALL grant a lone request immediately in both builds.

Verification
REQ-026 SHALL verify: i_d_req=1 op=0 addr=0x80001000 bytes=7 -> o_cache_req=1 next cycle with matching fields; i_cache_ack with rdata=0x1122334455667788 -> o_d_ack=1 one cycle later with o_d_rdata=0x1122334455667788.
REQ-027 SHALL verify: i_d_req and i_i_req raised in the same cycle, macro undefined, three back-to-back rounds -> data granted each round, instruction granted only after data is dropped.
REQ-028 SHALL verify: the same stimulus with YSYX210544_DCACHE_ARB_RR_EN defined -> grant order D, I, D.
REQ-029 SHALL verify: write op=1 wdata=0xDEAD bytes=1 -> o_cache_wdata=0xDEAD, and o_i_ack/o_d_ack rdata=0 after ack.
REQ-030 SHALL verify: rst asserted in BUSY_I -> next cycle o_cache_req=0, o_busy=0, no o_i_ack; a later i_cache_ack is ignored.
REQ-031 SHALL verify: i_cache_ack held off 20 cycles -> o_cache_* stable throughout, o_busy=1 throughout.
